// File: rtl/timer_pkg.sv
// timer_pkg: register map, servicer state encoding and event record for the timer IRQ servicer
package timer_pkg;

    localparam logic [5:0] REG_CTRL    = 6'h00;
    localparam logic [5:0] REG_LOAD    = 6'h04;
    localparam logic [5:0] REG_VAL     = 6'h08;
    localparam logic [5:0] REG_PRE     = 6'h0C;
    localparam logic [5:0] REG_INT_EN  = 6'h10;
    localparam logic [5:0] REG_INT_STS = 6'h14;
    localparam logic [5:0] REG_CMP     = 6'h18;
    localparam logic [5:0] REG_CAP     = 6'h1C;

    typedef enum logic [2:0] {
        IDLE,
        RD_STS,
        RD_CAP,
        RD_VAL,
        CLR,
        PUSH
    } state_t;

    // typ[0] = expire, typ[1] = capture
    typedef struct packed {
        logic [1:0]  typ;
        logic [31:0] cap;
        logic [31:0] val;
    } timer_evt_t;

endpackage

// File: rtl/timer_evt_fifo.sv
// timer_evt_fifo: synchronous event FIFO with valid/ready pop and a full flag
module timer_evt_fifo
    import timer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  timer_evt_t din,
    input  logic       ready,
    output timer_evt_t dout,
    output logic       valid,
    output logic       full
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    timer_evt_t    mem [DEPTH];
    logic          pop;
    logic          do_push;

    assign valid   = count != '0;
    assign full    = count == (AW + 1)'(DEPTH);
    assign pop     = valid && ready;
    assign do_push = push && (!full || pop);
    assign dout    = mem[rd_ptr];

    // Pointers and occupancy; a push into a full FIFO is accepted only alongside a pop
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW + 1)'(do_push) - (AW + 1)'(pop);
        end
    end

    // Storage needs no reset: entries are only visible once count covers them
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/timer_irq_servicer.sv
// timer_irq_servicer: arbitrates the timer register bus and services its interrupt in hardware
module timer_irq_servicer
    import timer_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_DEFER  = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        h_cs,
    input  logic        h_we,
    input  logic [5:0]  h_addr,
    input  logic [31:0] h_wdata,
    output logic [31:0] h_rdata,
    output logic        h_gnt,
    output logic        cs,
    output logic        we,
    output logic [5:0]  addr,
    output logic [31:0] wdata,
    input  logic [31:0] rdata,
    input  logic        intr_i,
    output logic        evt_valid,
    input  logic        evt_ready,
    output logic [1:0]  evt_type,
    output logic [31:0] evt_cap,
    output logic [31:0] evt_val,
    output logic        ovf_o,
    input  logic        ovf_clr
);

    state_t     state;
    state_t     state_nx;
    logic [1:0] sts;
    logic [31:0] cap;
    logic [31:0] val;
    logic [7:0] defer;
    logic       defer_hit;
    logic       push;
    logic       pop;
    logic       fifo_full;
    timer_evt_t head;

    assign defer_hit = defer == 8'(MAX_DEFER - 1);
    assign pop       = evt_valid && evt_ready;
    assign h_rdata   = h_gnt ? rdata : '0;
    assign evt_type  = head.typ;
    assign evt_cap   = head.cap;
    assign evt_val   = head.val;

    // Bus mux and service sequencing; the host owns the bus only in IDLE
    always_comb begin
        state_nx = state;
        cs       = 1'b0;
        we       = 1'b0;
        addr     = '0;
        wdata    = '0;
        h_gnt    = 1'b0;
        push     = 1'b0;
        case (state)
            IDLE: begin
                cs    = h_cs;
                we    = h_we;
                addr  = h_addr;
                wdata = h_wdata;
                h_gnt = 1'b1;
                if (intr_i && (!h_cs || defer_hit)) state_nx = RD_STS;
            end
            RD_STS: begin
                cs       = 1'b1;
                addr     = REG_INT_STS;
                state_nx = (rdata[1:0] == 2'b00) ? IDLE : rdata[1] ? RD_CAP : RD_VAL;
            end
            RD_CAP: begin
                cs       = 1'b1;
                addr     = REG_CAP;
                state_nx = RD_VAL;
            end
            RD_VAL: begin
                cs       = 1'b1;
                addr     = REG_VAL;
                state_nx = CLR;
            end
            CLR: begin
                cs       = 1'b1;
                we       = 1'b1;
                addr     = REG_INT_STS;
                wdata    = {30'b0, sts};
                state_nx = PUSH;
            end
            PUSH: begin
                push     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // State, captured register values, host-deferral counter and sticky overflow
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            sts   <= '0;
            cap   <= '0;
            val   <= '0;
            defer <= '0;
            ovf_o <= 1'b0;
        end else begin
            state <= state_nx;
            defer <= (state == IDLE && intr_i && h_cs && state_nx == IDLE) ? defer + 8'd1 : 8'd0;
            if (state == RD_STS) begin
                sts <= rdata[1:0];
                cap <= '0;
            end
            if (state == RD_CAP) cap <= rdata;
            if (state == RD_VAL) val <= rdata;
            ovf_o <= (push && fifo_full && !pop) ? 1'b1 : ovf_clr ? 1'b0 : ovf_o;
        end
    end

    timer_evt_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk  (clk),
        .rst_n(rst_n),
        .push (push),
        .din  ('{typ: sts, cap: cap, val: val}),
        .ready(evt_ready),
        .dout (head),
        .valid(evt_valid),
        .full (fifo_full)
    );

endmodule

// File: tb/tb_timer_irq_servicer.sv
// tb_timer_irq_servicer: directed vectors and service sequences against a small timer register model
module tb_timer_irq_servicer;
    import timer_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        h_cs, h_we;
    logic [5:0]  h_addr;
    logic [31:0] h_wdata, h_rdata;
    logic        h_gnt;
    logic        cs, we;
    logic [5:0]  addr;
    logic [31:0] wdata, rdata;
    logic        intr_i;
    logic        evt_valid, evt_ready;
    logic [1:0]  evt_type;
    logic [31:0] evt_cap, evt_val;
    logic        ovf_o, ovf_clr;

    int checks = 0;
    int failures = 0;

    logic [1:0]  sts_m = 2'b00;
    logic [1:0]  sts_set = 2'b00;
    logic        intr_q = 1'b0;
    logic        intr_force = 1'b0;
    logic [31:0] cap_m = '0;
    logic [31:0] val_m = '0;
    logic        rd_force = 1'b0;
    logic [31:0] rd_force_val = '0;

    typedef struct {
        logic        hcs;
        logic        hwe;
        logic [5:0]  ha;
        logic [31:0] hw;
        logic [31:0] rd;
        logic        ecs;
        logic        ewe;
        logic [5:0]  ea;
        logic [31:0] ew;
        logic [31:0] erd;
    } vec_t;

    vec_t tv[4];

    always #5 clk = ~clk;

    timer_irq_servicer #(.FIFO_DEPTH(4), .MAX_DEFER(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .h_cs(h_cs), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
        .h_rdata(h_rdata), .h_gnt(h_gnt),
        .cs(cs), .we(we), .addr(addr), .wdata(wdata), .rdata(rdata),
        .intr_i(intr_i),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_type(evt_type),
        .evt_cap(evt_cap), .evt_val(evt_val),
        .ovf_o(ovf_o), .ovf_clr(ovf_clr)
    );

    // Timer model: W1C status register, interrupt line lags status by one cycle
    always @(posedge clk) begin
        sts_m  <= (sts_m & ~((cs && we && addr == 6'h14) ? wdata[1:0] : 2'b00)) | sts_set;
        intr_q <= |sts_m;
    end

    assign intr_i = intr_q | intr_force;
    assign rdata  = rd_force ? rd_force_val :
                    addr == 6'h14 ? {30'b0, sts_m} :
                    addr == 6'h1C ? cap_m :
                    addr == 6'h08 ? val_m : (32'hDEAD_0000 | {26'b0, addr});

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic trigger(input logic [1:0] s, input logic [31:0] c, input logic [31:0] v);
        cap_m   = c;
        val_m   = v;
        sts_set = s;
        step();
        sts_set = 2'b00;
    endtask

    task automatic wait_busy(input string name);
        int n = 0;
        while (h_gnt && n < 50) begin
            step();
            n++;
        end
        chk({name, "_start"}, {31'b0, h_gnt}, 32'd0);
    endtask

    // Walks one service sequence from the RD_STS cycle to the first IDLE cycle after PUSH
    task automatic check_seq(input string t, input logic [1:0] s, input logic v_push);
        chk({t, "_sts_cswe"}, {30'b0, cs, we}, 32'd2);
        chk({t, "_sts_addr"}, {26'b0, addr}, 32'h14);
        chk({t, "_sts_gnt"}, {31'b0, h_gnt}, 32'd0);
        chk({t, "_sts_hrdata"}, h_rdata, 32'd0);
        step();
        if (s[1]) begin
            chk({t, "_cap_cswe"}, {30'b0, cs, we}, 32'd2);
            chk({t, "_cap_addr"}, {26'b0, addr}, 32'h1C);
            step();
        end
        chk({t, "_val_cswe"}, {30'b0, cs, we}, 32'd2);
        chk({t, "_val_addr"}, {26'b0, addr}, 32'h08);
        step();
        chk({t, "_clr_cswe"}, {30'b0, cs, we}, 32'd3);
        chk({t, "_clr_addr"}, {26'b0, addr}, 32'h14);
        chk({t, "_clr_wdata"}, wdata, {30'b0, s});
        step();
        chk({t, "_push_cs"}, {31'b0, cs}, 32'd0);
        chk({t, "_push_gnt"}, {31'b0, h_gnt}, 32'd0);
        chk({t, "_push_valid"}, {31'b0, evt_valid}, {31'b0, v_push});
        step();
        chk({t, "_idle_gnt"}, {31'b0, h_gnt}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int wr;
        tv[0] = '{1'b1, 1'b0, 6'h08, 32'h0,    32'h1234_5678, 1'b1, 1'b0, 6'h08, 32'h0,    32'h1234_5678};
        tv[1] = '{1'b1, 1'b1, 6'h14, 32'h3,    32'h0000_CAFE, 1'b1, 1'b1, 6'h14, 32'h3,    32'h0000_CAFE};
        tv[2] = '{1'b0, 1'b0, 6'h00, 32'h0,    32'hFFFF_FFFF, 1'b0, 1'b0, 6'h00, 32'h0,    32'hFFFF_FFFF};
        tv[3] = '{1'b1, 1'b1, 6'h3F, 32'hA5A5, 32'h0,         1'b1, 1'b1, 6'h3F, 32'hA5A5, 32'h0};

        rst_n = 1'b0; h_cs = 1'b0; h_we = 1'b0; h_addr = '0; h_wdata = '0;
        evt_ready = 1'b0; ovf_clr = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        chk("rst_gnt", {31'b0, h_gnt}, 32'd1);
        chk("rst_valid", {31'b0, evt_valid}, 32'd0);
        chk("rst_ovf", {31'b0, ovf_o}, 32'd0);
        chk("rst_cs", {31'b0, cs}, 32'd0);

        // Host passthrough in IDLE
        rd_force = 1'b1;
        for (int i = 0; i < 4; i++) begin
            h_cs = tv[i].hcs; h_we = tv[i].hwe; h_addr = tv[i].ha; h_wdata = tv[i].hw;
            rd_force_val = tv[i].rd;
            #1;
            chk($sformatf("pass%0d_cs", i), {31'b0, cs}, {31'b0, tv[i].ecs});
            chk($sformatf("pass%0d_we", i), {31'b0, we}, {31'b0, tv[i].ewe});
            chk($sformatf("pass%0d_addr", i), {26'b0, addr}, {26'b0, tv[i].ea});
            chk($sformatf("pass%0d_wdata", i), wdata, tv[i].ew);
            chk($sformatf("pass%0d_hrdata", i), h_rdata, tv[i].erd);
            chk($sformatf("pass%0d_gnt", i), {31'b0, h_gnt}, 32'd1);
            step();
        end
        rd_force = 1'b0;
        h_cs = 1'b0; h_we = 1'b0; h_addr = '0; h_wdata = '0;
        step();

        // Capture plus expire
        trigger(2'b11, 32'h0000_AA55, 32'h10);
        wait_busy("t2");
        check_seq("t2", 2'b11, 1'b0);
        chk("t2_valid", {31'b0, evt_valid}, 32'd1);
        chk("t2_type", {30'b0, evt_type}, 32'd3);
        chk("t2_cap", evt_cap, 32'h0000_AA55);
        chk("t2_val", evt_val, 32'h10);
        evt_ready = 1'b1; step(); evt_ready = 1'b0;

        // Expire only; CAP must read back as 0 despite the previous capture
        trigger(2'b01, 32'hBEEF, 32'h1234);
        wait_busy("t1");
        check_seq("t1", 2'b01, 1'b0);
        chk("t1_valid", {31'b0, evt_valid}, 32'd1);
        chk("t1_type", {30'b0, evt_type}, 32'd1);
        chk("t1_cap", evt_cap, 32'd0);
        chk("t1_val", evt_val, 32'h1234);
        evt_ready = 1'b1; step(); evt_ready = 1'b0;
        chk("t1_popped", {31'b0, evt_valid}, 32'd0);

        // Host contention: MAX_DEFER granted cycles, then forced service
        h_cs = 1'b1; h_we = 1'b0; h_addr = 6'h08;
        trigger(2'b01, 32'h0, 32'h77);
        n = 0;
        for (int k = 0; k < 40; k++) begin
            if (!h_gnt) break;
            if (intr_i) n++;
            step();
        end
        chk("t3_defer_cycles", n, 32'd8);
        check_seq("t3", 2'b01, 1'b0);
        chk("t3_host_rdata", h_rdata, 32'h77);
        h_cs = 1'b0; h_addr = '0;
        evt_ready = 1'b1; step(); evt_ready = 1'b0;

        // Spurious interrupt
        intr_force = 1'b1;
        wait_busy("t4");
        intr_force = 1'b0;
        chk("t4_cswe", {30'b0, cs, we}, 32'd2);
        chk("t4_addr", {26'b0, addr}, 32'h14);
        step();
        chk("t4_gnt_back", {31'b0, h_gnt}, 32'd1);
        chk("t4_no_write", {31'b0, cs}, 32'd0);
        step();
        chk("t4_no_push", {31'b0, evt_valid}, 32'd0);
        chk("t4_still_idle", {31'b0, h_gnt}, 32'd1);

        // Overflow with a stalled consumer
        for (int i = 0; i < 5; i++) begin
            trigger(2'b01, 32'h0, 32'h100 + i);
            wait_busy($sformatf("t5_%0d", i));
            check_seq($sformatf("t5_%0d", i), 2'b01, i > 0);
            if (i == 3) chk("t5_no_ovf", {31'b0, ovf_o}, 32'd0);
        end
        chk("t5_ovf", {31'b0, ovf_o}, 32'd1);
        ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
        chk("t5_ovf_clr", {31'b0, ovf_o}, 32'd0);
        evt_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t5_drain%0d_valid", i), {31'b0, evt_valid}, 32'd1);
            chk($sformatf("t5_drain%0d_val", i), evt_val, 32'h100 + i);
            step();
        end
        evt_ready = 1'b0;
        chk("t5_empty", {31'b0, evt_valid}, 32'd0);

        // Reset during CLR with one event already queued
        trigger(2'b01, 32'h0, 32'h55);
        wait_busy("t6a");
        check_seq("t6a", 2'b01, 1'b0);
        chk("t6_queued", {31'b0, evt_valid}, 32'd1);
        trigger(2'b01, 32'h0, 32'h66);
        wait_busy("t6");
        for (int k = 0; k < 6; k++) begin
            if (cs && we) break;
            step();
        end
        chk("t6_found_clr", {30'b0, cs, we}, 32'd3);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("t6_gnt", {31'b0, h_gnt}, 32'd1);
        chk("t6_valid", {31'b0, evt_valid}, 32'd0);
        chk("t6_ovf", {31'b0, ovf_o}, 32'd0);
        chk("t6_cs", {31'b0, cs}, 32'd0);
        wr = 0;
        for (int k = 0; k < 8; k++) begin
            if (cs && we) wr++;
            step();
        end
        chk("t6_no_write", wr, 32'd0);
        chk("t6_no_push", {31'b0, evt_valid}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/timer_irq_servicer.md
Name: timer_irq_servicer

Overview:
- Hardware interrupt servicer and bus arbiter for the general timer's register block.
- Sits between the host (firmware) port and the timer's generic cs/we/addr/wdata/rdata register bus.
- When the timer interrupt fires, it takes the bus and runs a fixed read/clear sequence:
  - reads INT_STS, then CAP if needed, then VAL;
  - W1C-clears exactly the status bits it observed;
  - pushes a timestamped event record into a FIFO for a downstream consumer.
- The host otherwise has the bus, and is stalled via h_gnt while a sequence runs.

Parameters:
- FIFO_DEPTH, 4, event FIFO entries; power of 2, range 2 to 16.
- MAX_DEFER, 8, cycles a pending interrupt may be deferred by continuous host traffic before the servicer forces ownership; range 1 to 255.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, synchronous, active-low
- h_cs  in  1  host select
- h_we  in  1  host write
- h_addr  in  6  host address
- h_wdata  in  32  host write data
- h_rdata  out  32  host read data; equals rdata when h_gnt=1, else 0
- h_gnt  out  1  host access accepted this cycle; host holds h_* stable until h_gnt=1
- cs  out  1  register bus select
- we  out  1  register bus write
- addr  out  6  register bus address
- wdata  out  32  register bus write data
- rdata  in  32  register bus read data, combinational, same cycle
- intr_i  in  1  timer interrupt, level
- evt_valid  out  1  FIFO head valid
- evt_ready  in  1  consumer accepts head
- evt_type  out  2  status bits captured: [0] expire, [1] capture
- evt_cap  out  32  CAP value; 0 if evt_type[1]=0
- evt_val  out  32  VAL counter value at service time
- ovf_o  out  1  sticky: event dropped because FIFO was full
- ovf_clr  in  1  clears ovf_o

Behaviour:
- All state changes on the rising edge of clk.
- rst_n=0 at an edge:
  - state=IDLE, FIFO empty, defer counter=0, ovf_o=0, latched status=0.
  - From the following cycle: cs=we=0, addr=wdata=0, evt_valid=0, h_gnt per IDLE rules.
  - Reset mid-sequence abandons it; no partial push, no W1C issued.
- Bus outputs are combinational from the registered state and the h_* inputs.
- States: IDLE, RD_STS, RD_CAP, RD_VAL, CLR, PUSH.
- IDLE:
  - Bus = host passthrough: cs=h_cs, we=h_we, addr=h_addr, wdata=h_wdata; h_gnt=1.
  - If intr_i=1 and h_cs=0, go to RD_STS next cycle.
  - If intr_i=1 and h_cs=1, increment defer counter. When it reaches MAX_DEFER, go to RD_STS regardless of h_cs; the host access in that cycle still completes.
  - Defer counter clears on leaving IDLE or when intr_i=0.
- In all non-IDLE states, h_gnt=0 and h_rdata=0.
- RD_STS: cs=1, we=0, addr=0x14; latch sts=rdata[1:0].
  - sts=00 (host already cleared) → IDLE, no push.
  - sts[1]=1 → RD_CAP.
  - Otherwise → RD_VAL.
- RD_CAP: read 0x1C, latch cap → RD_VAL. If this state is skipped, cap is latched as 0.
- RD_VAL: read 0x08, latch val → CLR.
- CLR: cs=1, we=1, addr=0x14, wdata={30'b0, sts} → PUSH. Bits not observed are never cleared, so events arriving mid-sequence are not lost.
- PUSH: cs=0.
  - If FIFO not full, or full with a pop this cycle, enqueue {sts, cap, val}.
  - Otherwise drop the record and set ovf_o=1.
  - → IDLE. PUSH also covers the one-cycle lag of intr_i after the W1C.
- Sequence length: 4 bus cycles (RD_STS, RD_VAL, CLR, PUSH), or 5 with RD_CAP. Earliest re-service is 1 cycle after PUSH.
- FIFO:
  - evt_* show the head combinationally from registered storage.
  - Pop when evt_valid and evt_ready.
  - Push to an empty FIFO makes evt_valid=1 the next cycle (no bypass).
  - Pointers wrap modulo FIFO_DEPTH; the count field is one bit wider than the pointers.
- ovf_o: set has priority over ovf_clr in the same cycle.

Decomposition:
- Shared package timer_pkg holds:
  - register offset constants (CTRL 0x00, LOAD 0x04, VAL 0x08, PRE 0x0C, INT_EN 0x10, INT_STS 0x14, CMP 0x18, CAP 0x1C);
  - the state enum;
  - packed struct timer_evt_t {type[1:0], cap[31:0], val[31:0]}.
- One sub-module, timer_evt_fifo: synchronous FIFO of timer_evt_t, parameterised by depth, with valid/ready pop and full flag.

Test Plan:
1. Expire only, bus idle: intr_i rises with rdata at 0x14 = 0x1 and 0x08 = 0x1234.
   - Bus sequence is read 0x14, read 0x08, write 0x14 data 0x1.
   - evt_valid=1 with type=01, cap=0, val=0x1234.
   - h_gnt=0 for exactly 4 cycles.
2. Capture plus expire: status 0x3, CAP 0xAA55, VAL 0x10.
   - Reads 0x14, 0x1C, 0x08, then writes 0x3.
   - Event: type=11, cap=0xAA55, val=0x10.
3. Host contention: host drives h_cs=1 continuously while intr_i=1.
   - Host gets MAX_DEFER=8 granted cycles, then RD_STS starts; h_gnt=0 during the sequence.
   - The stalled host request completes the cycle after PUSH.
4. Spurious interrupt: INT_STS reads 0x0.
   - Back to IDLE after RD_STS; no write, no push, h_gnt low for 1 cycle.
5. Overflow: evt_ready=0 and 5 interrupts with FIFO_DEPTH=4.
   - 4 events are queued; the 5th is dropped and ovf_o=1.
   - ovf_clr pulse clears it. Draining yields the first 4 events in order.
6. Reset mid-op: rst_n=0 during CLR.
   - Next cycle: IDLE, evt_valid=0, ovf_o=0, no write observed after reset.
